// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a fixed-latency RAM port.
// Out-of-window addresses complete on the next cycle with an error.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned BLOCK_SIZE    = 128,
  parameter int unsigned RAM_DELAY     = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_valid_i,
  output logic                    m0_ready_o,
  input  logic [31:0]             m0_addr_i,
  input  logic [BLOCK_SIZE/8-1:0] m0_wstrb_i,
  input  logic [BLOCK_SIZE-1:0]   m0_wdata_i,
  output logic [BLOCK_SIZE-1:0]   m0_rdata_o,
  output logic                    m0_err_o,
  input  logic                    m1_valid_i,
  output logic                    m1_ready_o,
  input  logic [31:0]             m1_addr_i,
  input  logic [BLOCK_SIZE/8-1:0] m1_wstrb_i,
  input  logic [BLOCK_SIZE-1:0]   m1_wdata_i,
  output logic [BLOCK_SIZE-1:0]   m1_rdata_o,
  output logic                    m1_err_o,
  output logic [31:0]             mem_addr_o,
  output logic [BLOCK_SIZE-1:0]   mem_wdata_o,
  output logic [BLOCK_SIZE/8-1:0] mem_wstrb_o,
  output logic                    mem_rd_en_o,
  input  logic [BLOCK_SIZE-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic [1:0]              gnt_o
);

  localparam int unsigned StrbW = BLOCK_SIZE / 8;
  localparam int unsigned CntW  = $clog2(RAM_DELAY);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic [StrbW-1:0]      wstrb_q;

  logic                  any_req;
  logic                  pick_m1;
  logic [31:0]           sel_addr;
  logic [StrbW-1:0]      sel_wstrb;
  logic [BLOCK_SIZE-1:0] sel_wdata;
  logic                  sel_in_win;
  logic [BLOCK_SIZE-1:0] resp_data;

  always_comb begin
    any_req = m0_valid_i | m1_valid_i;
    pick_m1 = 1'b0;
    // On a tie the requester not served last wins.
    if (m0_valid_i && m1_valid_i) begin
      pick_m1 = ~last_grant_q;
    end else begin
      pick_m1 = m1_valid_i;
    end
    sel_addr   = pick_m1 ? m1_addr_i  : m0_addr_i;
    sel_wstrb  = pick_m1 ? m1_wstrb_i : m0_wstrb_i;
    sel_wdata  = pick_m1 ? m1_wdata_i : m0_wdata_i;
    sel_in_win = ((sel_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR);
    resp_data  = (wstrb_q == '0) ? mem_rdata_i : '0;
  end

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wstrb_q      <= '0;
      gnt_o        <= 2'b00;
      m0_ready_o   <= 1'b0;
      m1_ready_o   <= 1'b0;
      m0_err_o     <= 1'b0;
      m1_err_o     <= 1'b0;
      m0_rdata_o   <= '0;
      m1_rdata_o   <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_wstrb_o  <= '0;
      mem_rd_en_o  <= 1'b0;
    end else begin
      mem_wstrb_o <= '0;
      m0_ready_o  <= 1'b0;
      m1_ready_o  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q      <= pick_m1;
            last_grant_q <= pick_m1;
            gnt_o        <= pick_m1 ? 2'b10 : 2'b01;
            mem_addr_o   <= sel_addr;
            mem_wdata_o  <= sel_wdata;
            wstrb_q      <= sel_wstrb;
            if (sel_in_win) begin
              state_q     <= StAccess;
              cnt_q       <= CntW'(RAM_DELAY - 1);
              mem_wstrb_o <= sel_wstrb;
              mem_rd_en_o <= (sel_wstrb == '0);
            end else begin
              state_q <= StResp;
              if (pick_m1) begin
                m1_ready_o <= 1'b1;
                m1_err_o   <= 1'b1;
                m1_rdata_o <= '0;
              end else begin
                m0_ready_o <= 1'b1;
                m0_err_o   <= 1'b1;
                m0_rdata_o <= '0;
              end
            end
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            state_q     <= StResp;
            mem_rd_en_o <= 1'b0;
            if (owner_q) begin
              m1_ready_o <= 1'b1;
              m1_err_o   <= 1'b0;
              m1_rdata_o <= resp_data;
            end else begin
              m0_ready_o <= 1'b1;
              m0_err_o   <= 1'b0;
              m0_rdata_o <= resp_data;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          gnt_o   <= 2'b00;
        end
        default: begin
          state_q <= StIdle;
          gnt_o   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model of grant order, latency and response contents.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned BS   = 128;
  localparam int unsigned SW   = BS / 8;
  localparam int unsigned RD   = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] MASK = 32'h000f_ffff;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          m0_valid_i, m1_valid_i;
  logic          m0_ready_o, m1_ready_o;
  logic [31:0]   m0_addr_i, m1_addr_i;
  logic [SW-1:0] m0_wstrb_i, m1_wstrb_i;
  logic [BS-1:0] m0_wdata_i, m1_wdata_i;
  logic [BS-1:0] m0_rdata_o, m1_rdata_o;
  logic          m0_err_o, m1_err_o;
  logic [31:0]   mem_addr_o;
  logic [BS-1:0] mem_wdata_o;
  logic [SW-1:0] mem_wstrb_o;
  logic          mem_rd_en_o;
  logic [BS-1:0] mem_rdata_i;
  logic          busy_o;
  logic [1:0]    gnt_o;

  mem_arbiter #(
    .BLOCK_SIZE   (BS),
    .RAM_DELAY    (RD),
    .RAM_BASE_ADDR(BASE),
    .RAM_MASK_ADDR(MASK)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m0_valid_i (m0_valid_i),
    .m0_ready_o (m0_ready_o),
    .m0_addr_i  (m0_addr_i),
    .m0_wstrb_i (m0_wstrb_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_rdata_o (m0_rdata_o),
    .m0_err_o   (m0_err_o),
    .m1_valid_i (m1_valid_i),
    .m1_ready_o (m1_ready_o),
    .m1_addr_i  (m1_addr_i),
    .m1_wstrb_i (m1_wstrb_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_rdata_o (m1_rdata_o),
    .m1_err_o   (m1_err_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_rdata_i(mem_rdata_i),
    .busy_o     (busy_o),
    .gnt_o      (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Requester-side stimulus and reference model state.
  bit            v[2];
  logic [31:0]   a[2];
  logic [SW-1:0] s[2];
  logic [BS-1:0] d[2];
  logic [BS-1:0] rram;
  int            last_grant;
  logic [BS-1:0] exp_rd[2];
  bit            exp_er[2];

  task automatic chk(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    m0_valid_i  = v[0];
    m0_addr_i   = a[0];
    m0_wstrb_i  = s[0];
    m0_wdata_i  = d[0];
    m1_valid_i  = v[1];
    m1_addr_i   = a[1];
    m1_wstrb_i  = s[1];
    m1_wdata_i  = d[1];
    mem_rdata_i = rram;
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? m0_ready_o : m1_ready_o;
  endfunction

  function automatic logic [BS-1:0] rdat(input int i);
    return (i == 0) ? m0_rdata_o : m1_rdata_o;
  endfunction

  function automatic logic errf(input int i);
    return (i == 0) ? m0_err_o : m1_err_o;
  endfunction

  function automatic logic [BS-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int i, input logic [31:0] addr, input logic [SW-1:0] strb);
    v[i] = 1'b1;
    a[i] = addr;
    s[i] = strb;
    d[i] = rnd_blk();
  endtask

  task automatic rand_req(input int i);
    bit          inwin;
    logic [31:0] addr;
    logic [SW-1:0] strb;
    inwin = ($urandom_range(0, 3) != 0);
    addr  = inwin ? (BASE | ($urandom & MASK)) : $urandom;
    if (!inwin && ((addr & ~MASK) == BASE)) addr[31] = ~addr[31];
    strb = '0;
    if ($urandom_range(0, 1) == 1) begin
      strb = SW'($urandom);
      if (strb == '0) strb = 1;
    end
    set_req(i, addr, strb);
  endtask

  // Called at the falling edge of an idle cycle with requests already applied.
  // Follows one transaction to its ready pulse and checks it against the model.
  task automatic serve(input int drop_k, input bit raise_other);
    int  owner, other, lat, rd_cnt, ws_cnt;
    bit  inwin, is_rd, got;
    logic [SW-1:0] ws_seen;
    logic [BS-1:0] exp_data;
    chk("idle_busy", BS'(busy_o), BS'(0));
    chk("idle_gnt", BS'(gnt_o), BS'(0));
    chk("idle_rden", BS'(mem_rd_en_o), BS'(0));
    if (v[0] && v[1]) owner = (last_grant == 1) ? 0 : 1;
    else              owner = v[1] ? 1 : 0;
    other      = 1 - owner;
    last_grant = owner;
    inwin      = ((a[owner] & ~MASK) == BASE);
    is_rd      = (s[owner] == '0);
    lat        = inwin ? RD + 1 : 1;
    exp_data   = (inwin && is_rd) ? rram : '0;
    got = 1'b0; rd_cnt = 0; ws_cnt = 0; ws_seen = '0;
    for (int k = 1; k <= lat + 4 && !got; k++) begin
      @(negedge clk_i);
      if (mem_rd_en_o) rd_cnt++;
      if (mem_wstrb_o != '0) begin
        ws_cnt++;
        ws_seen = mem_wstrb_o;
      end
      chk("other_ready", BS'(rdy(other)), BS'(0));
      if (k == 1) begin
        chk("gnt", BS'(gnt_o), (owner == 1) ? BS'(2) : BS'(1));
        chk("busy", BS'(busy_o), BS'(1));
        if (inwin) begin
          chk("mem_addr", BS'(mem_addr_o), BS'(a[owner]));
          chk("mem_wdata", mem_wdata_o, d[owner]);
        end
      end
      if (rdy(owner)) begin
        got = 1'b1;
        chk("latency", BS'(k), BS'(lat));
        chk("rdata", rdat(owner), exp_data);
        chk("err", BS'(errf(owner)), BS'(!inwin));
        exp_rd[owner] = exp_data;
        exp_er[owner] = !inwin;
        chk("hold_rdata", rdat(other), exp_rd[other]);
        chk("hold_err", BS'(errf(other)), BS'(exp_er[other]));
      end
      if (k == drop_k) begin
        v[owner] = 1'b0;
        if (raise_other) v[other] = 1'b1;
        apply();
      end
    end
    chk("ready_seen", BS'(got), BS'(1));
    chk("rden_cycles", BS'(rd_cnt), (inwin && is_rd) ? BS'(RD) : BS'(0));
    chk("wstrb_cycles", BS'(ws_cnt), (inwin && !is_rd) ? BS'(1) : BS'(0));
    if (ws_cnt != 0) chk("wstrb_val", BS'(ws_seen), BS'(s[owner]));
    v[owner] = 1'b0;
    apply();
    @(negedge clk_i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = '0; s[i] = '0; d[i] = '0;
      exp_rd[i] = '0; exp_er[i] = 1'b0;
    end
    last_grant = 1;
    rram   = '0;
    rst_ni = 1'b0;
    apply();
    repeat (2) @(negedge clk_i);
    chk("rst_busy", BS'(busy_o), BS'(0));
    chk("rst_gnt", BS'(gnt_o), BS'(0));
    chk("rst_ready", BS'({m0_ready_o, m1_ready_o}), BS'(0));
    chk("rst_rdata0", m0_rdata_o, '0);
    chk("rst_mem", BS'({mem_rd_en_o, mem_wstrb_o, mem_addr_o}), BS'(0));
    rst_ni = 1'b1;

    // Tie after reset: m0 first, then m1, then a fresh tie goes back to m0.
    rram = {16{8'hA5}};
    set_req(0, 32'h4000_0010, '0);
    set_req(1, 32'h4000_0200, '0);
    apply();
    serve(0, 1'b0);
    serve(0, 1'b0);
    set_req(0, 32'h4000_0300, '0);
    set_req(1, 32'h4000_0400, '0);
    apply();
    serve(0, 1'b0);
    serve(0, 1'b0);

    // m1 write, then m0 out-of-window read.
    rram = rnd_blk();
    set_req(1, 32'h4000_0020, 16'h000F);
    apply();
    serve(0, 1'b0);
    set_req(0, 32'h3000_0000, '0);
    apply();
    serve(0, 1'b0);

    // m0 drops valid mid-access while m1 starts waiting.
    rram = rnd_blk();
    set_req(0, 32'h4000_0040, '0);
    set_req(1, 32'h4000_0050, '0);
    v[1] = 1'b0;
    apply();
    serve(3, 1'b1);
    serve(0, 1'b0);

    // Reset in the 5th access cycle abandons the read.
    set_req(0, 32'h4000_0100, '0);
    apply();
    repeat (5) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_busy", BS'(busy_o), BS'(0));
    chk("midrst_gnt", BS'(gnt_o), BS'(0));
    chk("midrst_rden", BS'(mem_rd_en_o), BS'(0));
    chk("midrst_addr", BS'(mem_addr_o), BS'(0));
    chk("midrst_rdata1", m1_rdata_o, '0);
    v[0] = 1'b0;
    apply();
    repeat (2) begin
      @(negedge clk_i);
      chk("midrst_no_ready", BS'({m0_ready_o, m1_ready_o}), BS'(0));
    end
    rst_ni     = 1'b1;
    last_grant = 1;
    exp_rd[0]  = '0; exp_rd[1] = '0;
    exp_er[0]  = 1'b0; exp_er[1] = 1'b0;
    set_req(0, 32'h4000_0600, '0);
    set_req(1, 32'h4000_0700, 16'hFFFF);
    apply();
    serve(0, 1'b0);
    serve(0, 1'b0);

    // Random traffic; a waiting requester keeps its payload until served.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) rand_req(i);
      end
      if (!v[0] && !v[1]) rand_req(int'($urandom_range(0, 1)));
      rram = rnd_blk();
      apply();
      serve(0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): BLOCK_SIZE, 128, data width in bits; RAM_DELAY, 16, access cycles per RAM transaction (>=2); RAM_BASE_ADDR, 32'h4000_0000, RAM window base; RAM_MASK_ADDR, 32'h000f_ffff, RAM window offset mask.
REQ-002 SHALL have ports (name, direction, width, meaning) in this order: clk_i, in, 1, the single clock; rst_ni, in, 1, reset, asynchronous and active-low.
REQ-003 SHALL have, for each requester n in {0,1}: mn_valid_i, in, 1, request; mn_ready_o, out, 1, completion strobe; mn_addr_i, in, 32, byte address; mn_wstrb_i, in, BLOCK_SIZE/8, byte write enables (all zero = read); mn_wdata_i, in, BLOCK_SIZE, write data; mn_rdata_o, out, BLOCK_SIZE, read data; mn_err_o, out, 1, decode error, valid with mn_ready_o.
REQ-004 SHALL have memory-side ports: mem_addr_o, out, 32, latched address; mem_wdata_o, out, BLOCK_SIZE, latched write data; mem_wstrb_o, out, BLOCK_SIZE/8, write strobes; mem_rd_en_o, out, 1, read enable; mem_rdata_i, in, BLOCK_SIZE, RAM read data.
REQ-005 SHALL have status ports: busy_o, out, 1, state != IDLE; gnt_o, out, 2, one-hot current owner (00 in IDLE).

Function
REQ-006 SHALL implement three states: IDLE, ACCESS, RESP.
REQ-007 IDLE: with no valid requests, the block SHALL remain in IDLE and drive all memory-side enables low.
REQ-008 IDLE with exactly one valid request SHALL grant that requester.
REQ-009 IDLE with both requests valid SHALL grant the requester not granted last (round-robin via a last_grant bit); after reset, m0 wins the first tie.
REQ-010 On grant, the block SHALL latch addr, wdata and wstrb into internal registers, update last_grant and set gnt_o.
REQ-011 An in-window address is one where (addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR; an in-window grant SHALL go to ACCESS and load the down-counter with RAM_DELAY-1.
REQ-012 An out-of-window grant SHALL go directly to RESP with err=1 and rdata=0, and SHALL never assert a memory-side enable.
REQ-013 ACCESS: mem_addr_o/mem_wdata_o SHALL present the latched values every cycle.
REQ-014 ACCESS: mem_wstrb_o SHALL equal the latched wstrb in the first ACCESS cycle only and be zero otherwise.
REQ-015 ACCESS: mem_rd_en_o SHALL be 1 in every ACCESS cycle of a read (latched wstrb == 0) and 0 for writes.
REQ-016 ACCESS: the counter SHALL decrement each cycle; in the cycle it reads 0, the block SHALL capture mem_rdata_i into the response register (reads only) and move to RESP.
REQ-017 Counter width SHALL be $clog2(RAM_DELAY) bits and the counter SHALL never wrap below 0.
REQ-018 RESP: the block SHALL assert ready of the granted requester only, for exactly one cycle, with rdata/err valid in that cycle, then return to IDLE.
REQ-019 The non-granted requester's ready SHALL stay 0; its rdata_o/err_o SHALL hold their previous values.
REQ-020 Latency SHALL be: request sampled in IDLE at cycle T, in-window -> ready at T+RAM_DELAY+1; out-of-window -> ready at T+1.
REQ-021 Minimum spacing between grants SHALL be one IDLE cycle after RESP (no grant in the RESP cycle).
REQ-022 A requester SHALL hold valid and its payload until ready; deassertion of valid mid-transaction SHALL NOT abort the transaction — it completes, and the ready pulse is still issued.
REQ-023 A request arriving from the other requester during ACCESS/RESP SHALL wait and be granted in the next IDLE.
REQ-024 Write data SHALL not be returned: rdata_o on write completion SHALL be all-zero, err=0.

Reset
REQ-025 On rst_ni low the block SHALL asynchronously force: state=IDLE, counter=0, last_grant=1, gnt_o=00, busy_o=0, all ready/err=0, all rdata_o=0, mem_rd_en_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-026 Reset asserted mid-ACCESS SHALL abandon the transaction with no ready pulse; after release, the first tie SHALL go to m0.

Verification
REQ-027 m0 reads 0x4000_0010, RAM_DELAY=16, mem_rdata_i=0xA5..A5 -> mem_rd_en_o high 16 cycles, m0_ready_o single pulse at T+17 with m0_rdata_o=0xA5..A5, m0_err_o=0.
REQ-028 m0 and m1 valid in the same cycle after reset -> m0 served first, m1 granted in the IDLE after m0's RESP, a following tie grants m0 again.
REQ-029 m1 writes wstrb=16'h000F to 0x4000_0020 -> mem_wstrb_o=16'h000F for exactly one cycle, m1_ready_o at T+17, m1_rdata_o=0.
REQ-030 m0 reads 0x3000_0000 -> no memory enable, m0_ready_o at T+1 with m0_err_o=1, m0_rdata_o=0.
REQ-031 rst_ni pulsed low at the 5th ACCESS cycle -> outputs immediately at reset values, no ready pulse; a post-reset tie grants m0.
REQ-032 m0 drops valid in ACCESS -> transaction completes, m0_ready_o pulses once, next IDLE grants a waiting m1.
